fwd_hazard_unit: RTL
====================

Name: fwd_hazard_unit

Overview:
- Tracks destination-register info for instructions in the EX, MEM and WB stages of the 5-stage RV32I pipeline.
- Produces the 2-bit operand-select codes consumed by the EX-stage 3:1 forwarding muxes.
- Produces the load-use stall request for the IF/ID stages.
- Sits between ID decode and the EX-stage operand muxes; state advances in lock-step with the pipeline registers.

Parameters:
- REG_AW, 5, architectural register index width (x0..x31).
- CNT_W, 32, width of the stall counter (used only under the optional feature).

Ports:
- i_clk  input  1  pipeline clock; all state on rising edge
- i_rst  input  1  synchronous active-high reset
- i_id_valid  input  1  ID holds a real instruction
- i_id_rs1  input  REG_AW  ID source register 1
- i_id_rs2  input  REG_AW  ID source register 2
- i_id_use_rs1  input  1  ID instruction reads rs1
- i_id_use_rs2  input  1  ID instruction reads rs2
- i_id_rd  input  REG_AW  ID destination register
- i_id_rd_wen  input  1  ID instruction writes rd
- i_id_is_load  input  1  ID instruction is a load
- i_flush  input  1  branch/jump taken in EX; squash the ID instruction
- o_fwd_a  output  2  EX operand-A select: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
- o_fwd_b  output  2  EX operand-B select, same encoding
- o_stall  output  1  load-use stall: hold PC and IF/ID
- o_stall_cnt  output  CNT_W  stall-cycle count (only present with STALL_CNT_EN)

Behaviour:
- State is three entries, EX/MEM/WB. Each entry holds {valid, rd, rd_wen, is_load}. The EX entry also holds rs1/rs2 and use flags.
- Reset: all entries invalid, all fields 0. o_fwd_a = o_fwd_b = 2'b00; o_stall = 0; o_stall_cnt = 0. Reset wins over every other input.
- Each rising edge, in priority order:
  - MEM <= EX and WB <= MEM, always.
  - EX <= bubble (valid = 0) if i_flush or o_stall.
  - Otherwise EX <= ID fields, with valid = i_id_valid.
- Bubbles never forward and never stall.
- "Writer" definition: an entry is a writer if valid & rd_wen & rd != 0. x0 is never forwarded.
- o_fwd_a / o_fwd_b are combinational from registered state only (no input-to-output path), so they are valid early in the EX cycle.
- Forwarding select for operand A (B identical, using rs2/use_rs2):
  - 2'b01 if the MEM entry is a writer with rd == EX.rs1 and EX.use_rs1.
  - Else 2'b10 if the WB entry is a writer with a match.
  - Else 2'b00.
  - MEM has priority over WB when both match (youngest value wins).
  - EX entry invalid -> 2'b00.
- Code 2'b11 is never driven.
- o_stall is combinational and asserts when all of the following hold:
  - i_id_valid;
  - the EX entry is a writer with is_load;
  - rd matches rs1 (with use_rs1) or rs2 (with use_rs2).
- Exactly one bubble is inserted per load-use pair. On the next cycle the load is in MEM, so the stall condition clears and the consumer later receives 2'b10.
- i_flush in the same cycle as o_stall: the flush wins (EX <= bubble either way). o_stall still reflects its equation; upstream gives flush priority.
- Load in MEM matching EX operand: unreachable by construction. Sel 2'b01 is driven anyway, and the verification assertion flags it.
- Latency: an ID instruction appears in EX state 1 cycle after its non-stalled, non-flushed edge.

Optional Feature:
- Macro: FWD_HAZARD_STALL_CNT_EN.
- Defined:
  - o_stall_cnt port exists.
  - Counter increments on every edge where o_stall & ~i_rst.
  - Saturates at all-ones; does not wrap.
  - Cleared by i_rst.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package fwd_pkg:
  - fwd_sel_e enum (FWD_RF = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10);
  - REG_AW_DEF constant;
  - stage_entry_t packed struct {valid, rd, rd_wen, is_load}.
- One natural sub-module, fwd_sel_gen: combinational priority select for one operand, instantiated twice (A and B).

Test Plan:
- Reset: hold i_rst 2 cycles with random ID inputs -> fwd_a = fwd_b = 00, stall = 0, stall_cnt = 0.
- Back-to-back ALU ops: add x5 then sub x6, x5, x7 -> when sub is in EX, fwd_a = 01, fwd_b = 00.
- Distance-2 dependency with priority:
  - sequence add x5; add x5; or x8, x5, x5, with the two writers adjacent -> fwd_a = fwd_b = 01 (MEM beats WB);
  - with a nop between writer and reader -> 10.
- Load-use: lw x3 then add x4, x3, x1 -> stall = 1 for exactly 1 cycle, EX bubble inserted, then fwd_a = 10 when add reaches EX. stall_cnt = 1 with the feature enabled.
- x0 and flush:
  - addi x0 then use x0 -> sel 00;
  - lw x3 in EX with dependent ID and i_flush = 1 -> EX becomes bubble, no forward two cycles later.
- Counter saturation (feature on, CNT_W forced to 4): 20 stall cycles -> o_stall_cnt holds 4'hF.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types for the EX-stage forwarding and load-use hazard logic.
// Holds the operand-select encoding, the per-stage tracking entry and the writer test.
package fwd_pkg;

    localparam int REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_DEF-1:0] rd;
        logic                  rd_wen;
        logic                  is_load;
    } stage_entry_t;

    // x0 is hard-wired zero, so an instruction targeting it never
    // produces a value worth forwarding.
    function automatic logic is_writer(
        input logic                  valid,
        input logic                  rd_wen,
        input logic [REG_AW_DEF-1:0] rd
    );
        return valid & rd_wen & (rd != '0);
    endfunction

endpackage

// File: rtl/fwd_sel_gen.sv
// Priority operand-select for one EX operand: MEM over WB over regfile.
// Ports: ex_valid/rs/use_rs (EX consumer), mem_*/wb_* (producers), sel (mux code).
module fwd_sel_gen
    import fwd_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] rs,
    input  logic              use_rs,
    input  logic              mem_wr,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              wb_wr,
    input  logic [REG_AW-1:0] wb_rd,
    output fwd_sel_e          sel
);

    // MEM holds the younger producer, so it wins when both match.
    always_comb begin
        sel = FWD_RF;
        if (ex_valid && use_rs) begin
            if (mem_wr && (mem_rd == rs)) begin
                sel = FWD_MEM;
            end else if (wb_wr && (wb_rd == rs)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Tracks EX/MEM/WB destinations; drives EX forwarding selects and load-use stall.
// Ports: i_clk, i_rst (sync, active-high), i_id_* (decoded ID instr), i_flush,
//        o_fwd_a/o_fwd_b (00 rf, 01 EX/MEM, 10 MEM/WB), o_stall,
//        o_stall_cnt (only with FWD_HAZARD_STALL_CNT_EN defined).
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
`ifdef FWD_HAZARD_STALL_CNT_EN
   ,parameter int CNT_W = 32
`endif
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic              i_id_use_rs1,
    input  logic              i_id_use_rs2,
    input  logic [REG_AW-1:0] i_id_rd,
    input  logic              i_id_rd_wen,
    input  logic              i_id_is_load,
    input  logic              i_flush,
    output logic [1:0]        o_fwd_a,
    output logic [1:0]        o_fwd_b,
    output logic              o_stall
`ifdef FWD_HAZARD_STALL_CNT_EN
   ,output logic [CNT_W-1:0]  o_stall_cnt
`endif
);

    stage_entry_t      ex_q;
    stage_entry_t      mem_q;
    stage_entry_t      wb_q;
    logic [REG_AW-1:0] ex_rs1_q;
    logic [REG_AW-1:0] ex_rs2_q;
    logic              ex_use1_q;
    logic              ex_use2_q;

    logic     ex_wr;
    logic     mem_wr;
    logic     wb_wr;
    fwd_sel_e sel_a;
    fwd_sel_e sel_b;

    // Load flags of the older stages matter only to the assertion below.
    logic [1:0] unused_ld;
    assign unused_ld = {mem_q.is_load, wb_q.is_load};

    assign ex_wr  = is_writer(ex_q.valid, ex_q.rd_wen, ex_q.rd);
    assign mem_wr = is_writer(mem_q.valid, mem_q.rd_wen, mem_q.rd);
    assign wb_wr  = is_writer(wb_q.valid, wb_q.rd_wen, wb_q.rd);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            ex_rs1_q  <= '0;
            ex_rs2_q  <= '0;
            ex_use1_q <= 1'b0;
            ex_use2_q <= 1'b0;
        end else begin
            mem_q <= ex_q;
            wb_q  <= mem_q;
            // Flushed or stalled ID instruction leaves a bubble in EX.
            if (i_flush || o_stall) begin
                ex_q      <= '0;
                ex_rs1_q  <= '0;
                ex_rs2_q  <= '0;
                ex_use1_q <= 1'b0;
                ex_use2_q <= 1'b0;
            end else begin
                ex_q.valid   <= i_id_valid;
                ex_q.rd      <= i_id_rd;
                ex_q.rd_wen  <= i_id_rd_wen;
                ex_q.is_load <= i_id_is_load;
                ex_rs1_q     <= i_id_rs1;
                ex_rs2_q     <= i_id_rs2;
                ex_use1_q    <= i_id_use_rs1;
                ex_use2_q    <= i_id_use_rs2;
            end
        end
    end

    fwd_sel_gen #(.REG_AW(REG_AW)) u_sel_a (
        .ex_valid (ex_q.valid),
        .rs       (ex_rs1_q),
        .use_rs   (ex_use1_q),
        .mem_wr   (mem_wr),
        .mem_rd   (mem_q.rd),
        .wb_wr    (wb_wr),
        .wb_rd    (wb_q.rd),
        .sel      (sel_a)
    );

    fwd_sel_gen #(.REG_AW(REG_AW)) u_sel_b (
        .ex_valid (ex_q.valid),
        .rs       (ex_rs2_q),
        .use_rs   (ex_use2_q),
        .mem_wr   (mem_wr),
        .mem_rd   (mem_q.rd),
        .wb_wr    (wb_wr),
        .wb_rd    (wb_q.rd),
        .sel      (sel_b)
    );

    assign o_fwd_a = sel_a;
    assign o_fwd_b = sel_b;

    // Load data is not ready until MEM completes, so a dependent
    // instruction must wait one cycle and pick it up from WB.
    assign o_stall = i_id_valid & ex_wr & ex_q.is_load &
                     ((i_id_use_rs1 & (ex_q.rd == i_id_rs1)) |
                      (i_id_use_rs2 & (ex_q.rd == i_id_rs2)));

    // A load in MEM feeding EX means a stall was missed upstream.
    logic load_hit_mem;
    assign load_hit_mem = ex_q.valid & mem_wr & mem_q.is_load &
                          ((ex_use1_q & (mem_q.rd == ex_rs1_q)) |
                           (ex_use2_q & (mem_q.rd == ex_rs2_q)));

    a_no_load_in_mem: assert property (
        @(posedge i_clk) disable iff (i_rst) !load_hit_mem
    );

`ifdef FWD_HAZARD_STALL_CNT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_stall_cnt <= '0;
        end else if (o_stall && (o_stall_cnt != '1)) begin
            o_stall_cnt <= o_stall_cnt + 1'b1;
        end
    end
`endif

endmodule
